// File: rtl/line_buffer.sv
// Five-row vertical column tap for the LeNet window path.
// Four cascaded row delay lines, each delaying by the selected row width.
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] line_out_0,
    output logic [DATA_WIDTH-1:0] line_out_1,
    output logic [DATA_WIDTH-1:0] line_out_2,
    output logic [DATA_WIDTH-1:0] line_out_3,
    output logic [DATA_WIDTH-1:0] line_out_4
);

    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int IW = $clog2(MAX_WIDTH);

    logic [WW-1:0]         width_raw;
    logic [WW-1:0]         width;
    logic [IW-1:0]         tap_idx;
    logic [DATA_WIDTH-1:0] tap [4];
    logic [DATA_WIDTH-1:0] row_q [4][MAX_WIDTH];
    logic [DATA_WIDTH-1:0] row_d [4][MAX_WIDTH];

    always_comb begin
        width_raw = WW'(28);
        unique case (mode)
            3'd0:    width_raw = WW'(28);
            3'd1:    width_raw = WW'(24);
            3'd2:    width_raw = WW'(14);
            3'd3:    width_raw = WW'(12);
            3'd4:    width_raw = WW'(10);
            3'd5:    width_raw = WW'(8);
            default: width_raw = WW'(28);
        endcase
    end

    always_comb begin
        width = width_raw;
        if (width_raw > WW'(MAX_WIDTH)) begin
            width = WW'(MAX_WIDTH);
        end
        tap_idx = IW'(width - 1'b1);
    end

    // Taps move with mode immediately; stale entries are not flushed.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tap[k] = row_q[k][tap_idx];
        end
    end

    always_comb begin
        row_d = row_q;
        for (int k = 0; k < 4; k++) begin
            row_d[k][0] = (k == 3) ? data_in : tap[(k + 1) % 4];
            for (int i = 1; i < MAX_WIDTH; i++) begin
                row_d[k][i] = row_q[k][i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < MAX_WIDTH; i++) begin
                    row_q[k][i] <= '0;
                end
            end
        end else begin
            row_q <= row_d;
        end
    end

    assign line_out_0 = tap[0];
    assign line_out_1 = tap[1];
    assign line_out_2 = tap[2];
    assign line_out_3 = tap[3];
    assign line_out_4 = data_in;

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer against a pixel-history model.
// Expected columns are looked up from the list of pixels since reset.
module tb_line_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] line_out_0;
    logic [7:0] line_out_1;
    logic [7:0] line_out_2;
    logic [7:0] line_out_3;
    logic [7:0] line_out_4;

    line_buffer #(.DATA_WIDTH(8), .MAX_WIDTH(28)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .data_in    (data_in),
        .line_out_0 (line_out_0),
        .line_out_1 (line_out_1),
        .line_out_2 (line_out_2),
        .line_out_3 (line_out_3),
        .line_out_4 (line_out_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              chk;
        logic [4:0][7:0] e;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] hist[$];
    bit         known = 1'b0;
    logic [2:0] cur_mode = 3'd0;
    int         total = 0;
    int         bad = 0;

    function automatic int w_of(input logic [2:0] m);
        int w;
        case (m)
            3'd0: w = 28;
            3'd1: w = 24;
            3'd2: w = 14;
            3'd3: w = 12;
            3'd4: w = 10;
            3'd5: w = 8;
            default: w = 28;
        endcase
        if (w > 28) w = 28;
        return w;
    endfunction

    // Pixel from d rows back is the one accepted d*W clocks earlier.
    task automatic step(input logic r, input logic [2:0] m,
                        input logic [7:0] d);
        exp_t x;
        int   w;
        int   idx;
        @(posedge clk);
        #1;
        rst = r;
        mode = m;
        data_in = d;
        w = w_of(m);
        x.chk = known;
        x.e[4] = d;
        for (int k = 0; k < 4; k++) begin
            idx = hist.size() - (4 - k) * w;
            x.e[k] = (idx >= 0) ? hist[idx] : 8'd0;
        end
        sb_q.push_back(x);
        if (r) begin
            hist.delete();
            known = 1'b1;
        end else begin
            hist.push_back(d);
        end
    endtask

    task automatic spot(input string nm, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] e3, input logic [7:0] e4);
        logic [4:0][7:0] got;
        logic [4:0][7:0] req;
        #2;
        got = {line_out_4, line_out_3, line_out_2, line_out_1, line_out_0};
        req = {e4, e3, e2, e1, e0};
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, req);
        end
    endtask

    task automatic reset_to(input logic [2:0] m, input int n);
        step(1'b1, cur_mode, 8'd0);
        for (int i = 1; i < n; i++) step(1'b1, m, 8'd0);
        if (n < 2) step(1'b0, m, 8'd0);
        cur_mode = m;
    endtask

    always @(negedge clk) begin
        exp_t            x;
        logic [4:0][7:0] got;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            got = {line_out_4, line_out_3, line_out_2,
                   line_out_1, line_out_0};
            if (x.chk) begin
                for (int k = 0; k < 5; k++) begin
                    total++;
                    if (got[k] !== x.e[k]) begin
                        bad++;
                        $display("FAIL line_out_%0d t=%0t got=%h want=%h",
                                 k, $time, got[k], x.e[k]);
                    end
                end
            end
        end
    end

    task automatic ramp(input int n, input logic [2:0] m,
                        input int sv, input string nm,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        for (int v = 1; v <= n; v++) begin
            step(1'b0, m, 8'(v));
            if (v == sv) spot(nm, e0, e1, e2, e3, 8'(sv));
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1, 3'd0, 8'h00);
        step(1'b0, 3'd0, 8'h55);
        spot("reset_state", 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);

        reset_to(3'd0, 2);
        ramp(168, 3'd0, 150, "mode0_v150", 8'd38, 8'd66, 8'd94, 8'd122);

        reset_to(3'd3, 2);
        ramp(60, 3'd3, 60, "mode3_v60", 8'd12, 8'd24, 8'd36, 8'd48);

        reset_to(3'd0, 2);
        ramp(40, 3'd0, 40, "partial_v40", 8'd0, 8'd0, 8'd0, 8'd12);

        reset_to(3'd0, 2);
        ramp(130, 3'd0, 0, "", 8'd0, 8'd0, 8'd0, 8'd0);
        step(1'b1, 3'd0, 8'hA5);
        ramp(130, 3'd0, 100, "midrst_v100", 8'd0, 8'd16, 8'd44, 8'd72);

        reset_to(3'd7, 2);
        ramp(168, 3'd7, 150, "mode7_v150", 8'd38, 8'd66, 8'd94, 8'd122);

        for (int m = 1; m < 7; m++) begin
            reset_to(3'(m), 2);
            for (int i = 0; i < 4 * w_of(3'(m)) + 20; i++) begin
                step(1'b0, 3'(m), 8'($urandom));
            end
        end

        reset_to(3'($urandom_range(0, 7)), 2);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), cur_mode, 8'($urandom));
        end

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
